// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the rv32i instruction fetch queue: default widths,
// the default reset PC and a constant clog2 helper usable in port declarations.
package fetch_queue_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam int          ILEN         = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Ceiling log2, valid in constant expressions; returns 0 for values <= 1.
   function automatic int fq_clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Show-ahead FIFO holding {pc, instr} pairs for the fetch stage. The head entry
// is visible combinationally; flush empties it synchronously, reset asynchronously.
module fetch_queue_sync_fifo
   import fetch_queue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head_data,
   output logic [fq_clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (fq_clog2(DEPTH) < 1) ? 1 : fq_clog2(DEPTH);
   localparam int CW = fq_clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop on empty is ignored; a push on full only lands when a pop frees the slot.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   assign head_data = mem[rd_ptr];

   // Storage array carries no reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping, with flush dominating push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// IF stage for the rv32i pipeline: owns the PC, issues one-cycle-latency
// instruction memory requests, and queues returned words tagged with their PC
// toward decode. Redirects flush the queue and kill any outstanding request.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int              DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic                           imem_req_valid,
   output logic [XLEN-1:0]                imem_req_addr,
   input  logic                           imem_rsp_valid,
   input  logic [ILEN-1:0]                imem_rsp_data,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   output logic                           id_valid,
   input  logic                           id_ready,
   output logic [ILEN-1:0]                id_instr,
   output logic [XLEN-1:0]                id_pc,
   output logic [XLEN-1:0]                id_pc4,
   output logic [XLEN-1:0]                pc_out,
   output logic [fq_clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = fq_clog2(DEPTH + 1);

   logic [XLEN-1:0]      pc;
   logic                 inflight_valid;
   logic [XLEN-1:0]      inflight_pc;
   logic                 inflight_kill;
   logic                 reset_recent;
   logic                 push;
   logic                 pop;
   logic                 issue;
   logic [CW:0]          pending;
   logic [XLEN+ILEN-1:0] head_data;
   logic [XLEN-1:0]      head_pc;
   logic [ILEN-1:0]      head_instr;
   logic [1:0]           unused_redirect_lsbs;

   assign unused_redirect_lsbs = redirect_pc[1:0];

   // Redirect outranks everything: it suppresses pop, push and issue this cycle.
   assign pop  = id_valid && id_ready && !redirect_valid;
   assign push = imem_rsp_valid && inflight_valid && !inflight_kill && !redirect_valid;

   // Credit check counts the queued words plus the word still in flight, so a
   // response can never arrive to a full queue.
   assign pending = {1'b0, count} + (CW + 1)'(inflight_valid) - (CW + 1)'(pop);
   assign issue   = !redirect_valid && (pending < (CW + 1)'(DEPTH));

   assign imem_req_valid = issue && !reset;
   assign imem_req_addr  = pc;
   assign pc_out         = pc;

   assign head_pc    = head_data[XLEN+ILEN-1:ILEN];
   assign head_instr = head_data[ILEN-1:0];

   assign id_valid = (count != '0);
   assign id_instr = id_valid ? head_instr : '0;
   assign id_pc    = id_valid ? head_pc : '0;
   assign id_pc4   = id_valid ? (head_pc + XLEN'(4)) : '0;

   fetch_queue_sync_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({inflight_pc, imem_rsp_data}),
      .pop       (pop),
      .head_data (head_data),
      .count     (count)
   );

   // Fetch PC: redirect target (word aligned) wins, otherwise advance on issue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= RESET_PC;
      else if (redirect_valid)
         pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)
         pc <= pc + XLEN'(4);
   end

   // Outstanding request tracker; a redirect marks a still-pending word as dead.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
         inflight_kill  <= 1'b0;
      end else if (issue) begin
         inflight_valid <= 1'b1;
         inflight_pc    <= pc;
         inflight_kill  <= 1'b0;
      end else if (imem_rsp_valid) begin
         inflight_valid <= 1'b0;
         inflight_kill  <= 1'b0;
      end else if (redirect_valid) begin
         inflight_kill  <= inflight_valid;
      end
   end

   // Marks the first cycle after reset, when a pre-reset request may still answer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         reset_recent <= 1'b1;
      else
         reset_recent <= 1'b0;
   end

   // Orphan responses are only legal right after reset.
   a_rsp_has_owner : assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> (inflight_valid || reset_recent));

   // Credit accounting guarantees a push never meets a full queue.
   a_no_push_full : assert property (@(posedge clk) disable iff (reset)
      push |-> ((count != CW'(DEPTH)) || pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: two instances (RESET_PC 0 and a wrapping
// RESET_PC), behavioural memories, and a model tracking the next PC decode must see.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;

   logic        req_valid_a;
   logic [31:0] req_addr_a;
   logic        rsp_valid_a = 1'b0;
   logic [31:0] rsp_data_a  = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid_a;
   logic        id_ready;
   logic [31:0] id_instr_a;
   logic [31:0] id_pc_a;
   logic [31:0] id_pc4_a;
   logic [31:0] pc_out_a;
   logic [2:0]  count_a;

   logic        req_valid_b;
   logic [31:0] req_addr_b;
   logic        rsp_valid_b = 1'b0;
   logic [31:0] rsp_data_b  = 32'h0;
   logic        id_valid_b;
   logic [31:0] id_instr_b;
   logic [31:0] id_pc_b;
   logic [31:0] id_pc4_b;
   logic [31:0] pc_out_b;
   logic [2:0]  count_b;

   logic [31:0] exp_a;
   logic [31:0] exp_b;
   logic        steady;
   int          total;
   int          passes;
   int          fails;

   fetch_queue #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut_a (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (req_valid_a),
      .imem_req_addr  (req_addr_a),
      .imem_rsp_valid (rsp_valid_a),
      .imem_rsp_data  (rsp_data_a),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid_a),
      .id_ready       (id_ready),
      .id_instr       (id_instr_a),
      .id_pc          (id_pc_a),
      .id_pc4         (id_pc4_a),
      .pc_out         (pc_out_a),
      .count          (count_a)
   );

   fetch_queue #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_b (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (req_valid_b),
      .imem_req_addr  (req_addr_b),
      .imem_rsp_valid (rsp_valid_b),
      .imem_rsp_data  (rsp_data_b),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .id_valid       (id_valid_b),
      .id_ready       (1'b1),
      .id_instr       (id_instr_b),
      .id_pc          (id_pc_b),
      .id_pc4         (id_pc4_b),
      .pc_out         (pc_out_b),
      .count          (count_b)
   );

   always #5 clk = ~clk;

   // Instruction memories: one-cycle latency, word = address ^ A5A5_0000, never reset.
   always @(posedge clk) begin
      rsp_valid_a <= req_valid_a;
      rsp_data_a  <= req_addr_a ^ 32'hA5A5_0000;
      rsp_valid_b <= req_valid_b;
      rsp_data_b  <= req_addr_b ^ 32'hA5A5_0000;
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      total++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One cycle: drive inputs, check the visible head against the model, advance
   // the model by the handshake that is about to happen, then clock.
   task automatic apply_stimulus(input logic rdy, input logic redir, input logic [31:0] tgt);
      id_ready       = rdy;
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      if (id_valid_a) begin
         check_output("a_head_pc",    id_pc_a,    exp_a);
         check_output("a_head_instr", id_instr_a, exp_a ^ 32'hA5A5_0000);
         check_output("a_head_pc4",   id_pc4_a,   exp_a + 32'd4);
      end else begin
         check_output("a_idle_fields", {id_pc_a, id_instr_a ^ id_pc4_a}, 64'h0);
      end
      if (steady)
         check_output("a_no_bubble", id_valid_a, 1'b1);
      if (redir)
         check_output("a_redirect_no_req", req_valid_a, 1'b0);
      check_output("a_count_bound", count_a <= 3'(DEPTH), 1'b1);
      if (id_valid_b) begin
         check_output("b_head_pc",    id_pc_b,    exp_b);
         check_output("b_head_instr", id_instr_b, exp_b ^ 32'hA5A5_0000);
      end
      if (redir)
         exp_a = {tgt[31:2], 2'b00};
      else if (id_valid_a && rdy)
         exp_a = exp_a + 32'd4;
      if (id_valid_b)
         exp_b = exp_b + 32'd4;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      total = 0; passes = 0; fails = 0; steady = 1'b0;
      reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      exp_a = 32'h0000_0000; exp_b = 32'hFFFF_FFF8;
      #1;
      check_output("rst_req_valid", req_valid_a, 1'b0);
      check_output("rst_id_valid",  id_valid_a, 1'b0);
      check_output("rst_count",     count_a, 3'd0);
      check_output("rst_id_fields", {id_pc_a, id_instr_a}, 64'h0);
      check_output("rst_pc_a",      pc_out_a, 32'h0);
      check_output("rst_pc_b",      pc_out_b, 32'hFFFF_FFF8);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("first_req_valid", req_valid_a, 1'b1);
      check_output("first_req_addr",  req_addr_a, 32'h0);

      // Latency: request in cycle 0, data in cycle 1, id_valid in cycle 2.
      apply_stimulus(1'b1, 1'b0, 32'h0);
      check_output("lat_c1_valid", id_valid_a, 1'b0);
      apply_stimulus(1'b1, 1'b0, 32'h0);
      check_output("lat_c2_valid", id_valid_a, 1'b1);
      check_output("lat_c2_pc",    id_pc_a, 32'h0);
      check_output("wrap_first_pc", id_pc_b, 32'hFFFF_FFF8);
      steady = 1'b1;
      repeat (12) apply_stimulus(1'b1, 1'b0, 32'h0);

      // Stall decode long enough to fill the queue, then release.
      steady = 1'b0;
      repeat (10) apply_stimulus(1'b0, 1'b0, 32'h0);
      check_output("stall_count_full", count_a, 3'd4);
      check_output("stall_no_req",     req_valid_a, 1'b0);
      steady = 1'b1;
      repeat (10) apply_stimulus(1'b1, 1'b0, 32'h0);
      steady = 1'b0;

      // Redirect with three queued words and one in flight.
      apply_stimulus(1'b0, 1'b1, 32'h0000_0040);
      for (int i = 0; i < 10 && count_a != 3'd3; i++)
         apply_stimulus(1'b0, 1'b0, 32'h0);
      check_output("pre_redirect_count", count_a, 3'd3);
      check_output("pre_redirect_noreq", req_valid_a, 1'b0);
      apply_stimulus(1'b0, 1'b1, 32'h0000_0100);
      check_output("post_redirect_valid", id_valid_a, 1'b0);
      check_output("post_redirect_count", count_a, 3'd0);
      repeat (8) apply_stimulus(1'b1, 1'b0, 32'h0);

      // Redirect coinciding with pop and response; misaligned target.
      apply_stimulus(1'b1, 1'b1, 32'h0000_0103);
      check_output("coincide_valid", id_valid_a, 1'b0);
      check_output("coincide_pc",    pc_out_a, 32'h0000_0100);
      repeat (6) apply_stimulus(1'b1, 1'b0, 32'h0);

      // Back-to-back redirects: the later one wins.
      apply_stimulus(1'b1, 1'b1, 32'h0000_0200);
      apply_stimulus(1'b1, 1'b1, 32'h0000_0300);
      check_output("b2b_valid", id_valid_a, 1'b0);
      repeat (6) apply_stimulus(1'b1, 1'b0, 32'h0);

      // Reset pulsed between clock edges while a request is outstanding.
      #1 reset = 1'b1;
      #1;
      check_output("midrst_id_valid", id_valid_a, 1'b0);
      check_output("midrst_count",    count_a, 3'd0);
      check_output("midrst_fields",   {id_pc_a, id_pc4_a}, 64'h0);
      check_output("midrst_req",      req_valid_a, 1'b0);
      check_output("midrst_pc_b",     pc_out_b, 32'hFFFF_FFF8);
      #1 reset = 1'b0;
      exp_a = 32'h0000_0000;
      exp_b = 32'hFFFF_FFF8;
      apply_stimulus(1'b1, 1'b0, 32'h0);
      check_output("midrst_c1_valid", id_valid_a, 1'b0);
      apply_stimulus(1'b1, 1'b0, 32'h0);
      check_output("midrst_c2_pc", {31'h0, id_valid_a, id_pc_a}, {31'h0, 1'b1, 32'h0});
      repeat (4) apply_stimulus(1'b1, 1'b0, 32'h0);

      // Randomised ready and redirect traffic against the model.
      for (int i = 0; i < 400; i++)
         apply_stimulus($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 6, $urandom);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
